// File: rtl/song_stream_engine.sv
// Streams an interleaved multi-channel song from an Avalon read master into a sample FIFO; one frame per audio tick, strobed 1 cycle after the tick.
// Fetching stalls while the FIFO is full; paused or starved ticks never block the codec side.
module song_stream_engine #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_CH      = 2,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                PRIME_WORDS = 8,
  parameter logic [ADDR_W-1:0] SONG_BASE   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  input  logic                     loop_en_i,
  input  logic                     aud_tick_i,
  output logic                     tl_read_o,
  output logic [ADDR_W-1:0]        tl_addr_o,
  input  logic                     tl_rdv_i,
  input  logic [DATA_W-1:0]        tl_rdata_i,
  output logic [NUM_CH*DATA_W-1:0] sample_out_o,
  output logic                     sample_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [15:0]              underrun_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = CW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PRIME, S_PLAY, S_ABORT, S_FIN} state_t;

  state_t                    state_q;
  logic                      rd_q, os_q;
  logic [ADDR_W-1:0]         ptr_q;
  logic [31:0]               frames_q, words_q, words_left_q, frames_left_q;
  logic [PW-1:0]             pend_q;
  logic [DATA_W-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             cnt_q;
  logic [NUM_CH*DATA_W-1:0]  sample_q, frame_d;
  logic                      valid_q, done_q;
  logic [15:0]               urun_q;

  logic        fetch_act, rd_done, push, wrap, issue, tick, pop, have_pass, pass_roll;
  logic [31:0] f_hdr, w_hdr;

  assign fetch_act = (state_q == S_PRIME) || (state_q == S_PLAY);
  assign rd_done   = os_q && tl_rdv_i;
  assign push      = fetch_act && rd_done && !stop_i;
  assign wrap      = push && (words_left_q == 32'd1) && loop_en_i;
  assign issue     = !os_q && !stop_i &&
                     ((state_q == S_HDR) ||
                      (fetch_act && (words_left_q != 32'd0) && (cnt_q < CW'(FIFO_DEPTH))));
  assign tick      = (state_q == S_PLAY) && aud_tick_i && !pause_i && !stop_i;
  assign pop       = tick && (cnt_q >= CW'(NUM_CH));
  // pend_q counts loop passes already fetched ahead of the one being played
  assign have_pass = (pend_q != '0) || wrap;
  assign pass_roll = pop && (frames_left_q == 32'd1) && have_pass;
  assign f_hdr     = 32'(tl_rdata_i);
  assign w_hdr     = f_hdr * 32'(NUM_CH);

  always_comb begin
    frame_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      frame_d[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q + AW'(i)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tl_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      rd_q          <= 1'b0;
      os_q          <= 1'b0;
      ptr_q         <= '0;
      frames_q      <= '0;
      words_q       <= '0;
      words_left_q  <= '0;
      frames_left_q <= '0;
      pend_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      sample_q      <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      urun_q        <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (rd_done) begin
        rd_q <= 1'b0;
        os_q <= 1'b0;
      end
      if (issue) begin
        rd_q <= 1'b1;
        os_q <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(NUM_CH);
      cnt_q <= cnt_q + CW'(push) - (pop ? CW'(NUM_CH) : CW'(0));

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_HDR;
            ptr_q   <= SONG_BASE;
            urun_q  <= '0;
            pend_q  <= '0;
          end
        end
        S_HDR: begin
          if (rd_done) begin
            frames_q      <= f_hdr;
            words_q       <= w_hdr;
            words_left_q  <= w_hdr;
            frames_left_q <= f_hdr;
            if (f_hdr == 32'd0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= SONG_BASE + STEP;
              state_q <= S_PRIME;
            end
          end
        end
        S_PRIME, S_PLAY: begin
          if (push) begin
            if (wrap) begin
              ptr_q        <= SONG_BASE + STEP;
              words_left_q <= words_q;
            end else begin
              ptr_q        <= ptr_q + STEP;
              words_left_q <= words_left_q - 32'd1;
            end
          end
          pend_q <= pend_q + PW'(wrap) - PW'(pass_roll);
          if (state_q == S_PRIME) begin
            if ((cnt_q >= CW'(PRIME_WORDS)) || ((words_left_q == 32'd0) && !os_q))
              state_q <= S_PLAY;
          end else if (tick) begin
            valid_q <= 1'b1;
            if (pop) begin
              sample_q <= frame_d;
              if (frames_left_q != 32'd1) begin
                frames_left_q <= frames_left_q - 32'd1;
              end else if (have_pass) begin
                frames_left_q <= frames_q;
              end else begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end
            end else begin
              sample_q <= '0;
              if (urun_q != 16'hFFFF) urun_q <= urun_q + 16'd1;
            end
          end
        end
        S_ABORT: begin
          if (!os_q || tl_rdv_i) begin
            os_q    <= 1'b0;
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // FIN is already terminating; aborting there would only re-pulse done
      if (stop_i && (state_q != S_IDLE) && (state_q != S_ABORT) && (state_q != S_FIN)) begin
        state_q  <= S_ABORT;
        rd_q     <= 1'b0;
        os_q     <= os_q && !tl_rdv_i;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        valid_q  <= 1'b0;
        done_q   <= 1'b0;
      end
    end
  end

  assign tl_read_o      = rd_q;
  assign tl_addr_o      = ptr_q;
  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign underrun_cnt_o = urun_q;

endmodule
